// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// Port ids, one-hot FSM encoding, default timing limits and the debug view.
package mem_arbiter_pkg;

    localparam int DEF_MAX_WAIT    = 4;
    localparam int DEF_TIMEOUT_CYC = 1023;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_ISSUE = 3'b010,
        ST_DONE  = 3'b100
    } arb_state_e;

    // Fixed-width snapshot of internal state so checkers can bind without hierarchy.
    typedef struct packed {
        arb_state_e  state;
        logic        owner;
        logic [7:0]  starve;
        logic [15:0] timer;
    } arb_dbg_t;

    function automatic logic [1:0] port_sel(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester ports (index 0 = CPU, 1 = DMA) plus the single path to phy_mem_ctrl.
// Each reqN is held with addr/wdata/we until its 1-cycle ackN; mem_req is held until mem_ack.
interface mem_arbiter_if;

    logic [1:0]        req;
    logic [1:0][31:0]  addr;
    logic [1:0][31:0]  wdata;
    logic [1:0]        we;
    logic [1:0]        ack;
    logic [1:0][31:0]  rdata;
    logic [1:0]        err;

    logic              mem_req;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_data_out;
    logic              mem_is_write;
    logic [31:0]       mem_data_in;
    logic              mem_ack;

    modport slave (
        input  req, addr, wdata, we, mem_data_in, mem_ack,
        output ack, rdata, err, mem_req, mem_addr, mem_data_out, mem_is_write
    );

    modport master (
        output req, addr, wdata, we, mem_data_in, mem_ack,
        input  ack, rdata, err, mem_req, mem_addr, mem_data_out, mem_is_write
    );

endinterface

// File: rtl/mem_arbiter_timer.sv
// Clear/enable up-counter with terminal-count flag; used as the access watchdog.
// Holds at LIMIT-1 so a missed clear can never wrap into a false short timeout.
module mem_arbiter_timer #(
    parameter int LIMIT = 1023,
    parameter int W     = $clog2(LIMIT) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o  = (cnt_q == W'(LIMIT - 1));
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one SRAM path between CPU (port 0, priority) and DMA (port 1, anti-starvation).
// A hung access is aborted by the watchdog and completed with err on the owning port.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT    = DEF_MAX_WAIT,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus,
    output arb_dbg_t      dbg_o
);

    localparam int SW = $clog2(MAX_WAIT + 1);
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              abort_q, abort_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [1:0][31:0]  rdata_q, rdata_d;

    logic              req_any;
    logic              starve_full;
    logic              grant1;
    logic [TW-1:0]     tmr_cnt;
    logic              tmr_tc;
    logic              in_issue;

    assign in_issue = (state_q == ST_ISSUE);

    mem_arbiter_timer #(
        .LIMIT (TIMEOUT_CYC),
        .W     (TW)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (!in_issue),
        .en_i  (in_issue),
        .cnt_o (tmr_cnt),
        .tc_o  (tmr_tc)
    );

    assign req_any     = |bus.req;
    assign starve_full = (starve_q == SW'(MAX_WAIT));
    assign grant1      = bus.req[1] & (~bus.req[0] | starve_full);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        abort_d  = abort_q;
        starve_d = starve_q;
        rdata_d  = rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    owner_d = grant1 ? PORT_DMA : PORT_CPU;
                    addr_d  = bus.addr[grant1];
                    wdata_d = bus.wdata[grant1];
                    we_d    = bus.we[grant1];
                    abort_d = 1'b0;
                    state_d = ST_ISSUE;
                    // Only a CPU win that leaves the DMA waiting counts toward starvation.
                    if (grant1) begin
                        starve_d = '0;
                    end else if (bus.req[1] && !starve_full) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end

            ST_ISSUE: begin
                if (bus.mem_ack) begin
                    rdata_d[owner_q] = bus.mem_data_in;
                    state_d          = ST_DONE;
                end else if (tmr_tc) begin
                    rdata_d[owner_q] = '0;
                    abort_d          = 1'b1;
                    state_d          = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= PORT_CPU;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            abort_q  <= 1'b0;
            starve_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            abort_q  <= abort_d;
            starve_q <= starve_d;
            rdata_q  <= rdata_d;
        end
    end

    // All outputs come straight from registers, so reset clears them without waiting for a clock.
    assign bus.mem_req      = in_issue;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_data_out = wdata_q;
    assign bus.mem_is_write = we_q;
    assign bus.ack          = (state_q == ST_DONE) ? port_sel(owner_q) : 2'b00;
    assign bus.err          = bus.ack & {2{abort_q}};
    assign bus.rdata        = rdata_q;

    assign dbg_o.state  = state_q;
    assign dbg_o.owner  = owner_q;
    assign dbg_o.starve = 8'(starve_q);
    assign dbg_o.timer  = 16'(tmr_cnt);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter with a behavioural memory and arbitration model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int MAX_WAIT    = DEF_MAX_WAIT;
    localparam int TIMEOUT_CYC = DEF_TIMEOUT_CYC;
    localparam int WAIT_BOUND  = 8 * (TIMEOUT_CYC + 4);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();
    arb_dbg_t dbg;

    mem_arbiter #(
        .MAX_WAIT    (MAX_WAIT),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .dbg_o (dbg)
    );

    logic        tb_req[2];
    logic [31:0] tb_addr[2];
    logic [31:0] tb_wdata[2];
    logic        tb_we[2];
    int          cur_lat[2];
    logic        resp_ack  = 1'b0;
    logic [31:0] resp_data = '0;

    assign bus.req         = {tb_req[1], tb_req[0]};
    assign bus.addr        = {tb_addr[1], tb_addr[0]};
    assign bus.wdata       = {tb_wdata[1], tb_wdata[0]};
    assign bus.we          = {tb_we[1], tb_we[0]};
    assign bus.mem_ack     = resp_ack;
    assign bus.mem_data_in = resp_data;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];
    logic [31:0] ref_mem[int unsigned];
    logic [31:0] phy_mem[int unsigned];
    int grant_log[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] phy_read(input logic [31:0] a);
        return phy_mem.exists(a) ? phy_mem[a] : init_val(a);
    endfunction

    // ---------------- driver ----------------
    // k = cycles after the first mem_req cycle until mem_ack; k < 0 means the memory never answers.
    task automatic drive(input int p, input logic [31:0] a, input logic w, input logic [31:0] d,
                         input int k, input logic hold, output int lat);
        logic [31:0] old;
        logic        to;
        old = ref_read(a);
        to  = (k < 0) || (k > TIMEOUT_CYC - 1);
        if (p == 0) exp_q0.push_back({to, to ? 32'h0 : old});
        else        exp_q1.push_back({to, to ? 32'h0 : old});
        if (!to && w) ref_mem[a] = d;
        cur_lat[p]  = k;
        tb_addr[p]  = a;
        tb_we[p]    = w;
        tb_wdata[p] = d;
        tb_req[p]   = 1'b1;
        lat = 0;
        for (int n = 1; n <= WAIT_BOUND; n++) begin
            @(negedge clk);
            if (bus.ack[p]) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL ack_wait port%0d: actual=no ack required=ack within %0d cycles", p, WAIT_BOUND);
        end
        if (!hold || lat == 0) tb_req[p] = 1'b0;
    endtask

    // ---------------- phy_mem_ctrl model ----------------
    int rcyc = 0;
    always @(negedge clk) begin
        int owner_r;
        if (!rst) begin
            resp_ack = 1'b0;
            rcyc     = 0;
        end else begin
            resp_ack = 1'b0;
            if (bus.mem_req) begin
                owner_r = bus.mem_addr[13] ? 1 : 0;
                if (rcyc == cur_lat[owner_r]) begin
                    resp_ack  = 1'b1;
                    resp_data = phy_read(bus.mem_addr);
                    if (bus.mem_is_write) phy_mem[bus.mem_addr] = bus.mem_data_out;
                end
                rcyc++;
            end else begin
                rcyc = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    logic [1:0]  req_s;
    logic [31:0] addr_s[2];
    logic [31:0] wdata_s[2];
    logic        we_s[2];

    always @(posedge clk) begin
        req_s = {tb_req[1], tb_req[0]};
        for (int p = 0; p < 2; p++) begin
            addr_s[p]  = tb_addr[p];
            wdata_s[p] = tb_wdata[p];
            we_s[p]    = tb_we[p];
        end
    end

    int          starve_m = 0;
    int          owner_m = 0;
    int          len_m = 0;
    int          exp_len_m = 0;
    logic        prev_req_m = 1'b0;
    logic        stab_bad = 1'b0;
    logic [31:0] snap_addr, snap_data;
    logic        snap_we;

    always @(negedge clk) begin
        int w;
        int k;
        logic [32:0] e;
        if (!rst) begin
            starve_m   = 0;
            prev_req_m = 1'b0;
            len_m      = 0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (bus.ack[p]) begin
                    if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
                        check($sformatf("unexpected_ack_p%0d", p), 1, 0);
                    end else begin
                        if (p == 0) e = exp_q0.pop_front();
                        else        e = exp_q1.pop_front();
                        check($sformatf("resp_p%0d", p), {bus.err[p], bus.rdata[p]}, e);
                    end
                end else if (bus.err[p]) begin
                    check($sformatf("err_without_ack_p%0d", p), 1, 0);
                end
            end

            if (bus.mem_req && !prev_req_m) begin
                // Port 1 wins only when alone or after MAX_WAIT port-0 wins it waited through.
                w = (req_s[1] && (!req_s[0] || starve_m == MAX_WAIT)) ? 1 : 0;
                if (w == 1) starve_m = 0;
                else if (req_s[1] && starve_m < MAX_WAIT) starve_m++;
                check("grant_had_req", req_s[w], 1);
                check("grant_addr", bus.mem_addr, addr_s[w]);
                check("grant_we", bus.mem_is_write, we_s[w]);
                if (we_s[w]) check("grant_wdata", bus.mem_data_out, wdata_s[w]);
                owner_m = w;
                grant_log.push_back(w);
                k = cur_lat[w];
                exp_len_m = (k < 0 || k > TIMEOUT_CYC - 1) ? TIMEOUT_CYC : k + 1;
                len_m     = 1;
                stab_bad  = 1'b0;
                snap_addr = bus.mem_addr;
                snap_data = bus.mem_data_out;
                snap_we   = bus.mem_is_write;
            end else if (bus.mem_req) begin
                len_m++;
                if (bus.mem_addr !== snap_addr || bus.mem_data_out !== snap_data ||
                    bus.mem_is_write !== snap_we) stab_bad = 1'b1;
            end else if (prev_req_m) begin
                check("issue_len", len_m, exp_len_m);
                check("mem_stable", stab_bad, 0);
                check("ack_owner", bus.ack[owner_m], 1);
                check("ack_other", bus.ack[1 - owner_m], 0);
            end
            prev_req_m = bus.mem_req;
        end
    end

    // ---------------- stimulus ----------------
    int exp_pat[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    initial begin
        int lat, lat0, lat1;
        int seen;
        for (int p = 0; p < 2; p++) begin
            tb_req[p]   = 1'b0;
            tb_addr[p]  = '0;
            tb_wdata[p] = '0;
            tb_we[p]    = 1'b0;
            cur_lat[p]  = 0;
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_ack", bus.ack, 0);
        check("rst_err", bus.err, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_data_out", bus.mem_data_out, 0);
        check("rst_mem_is_write", bus.mem_is_write, 0);
        check("rst_state", dbg.state, ST_IDLE);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Read returning 0xCAFEF00D with mem_ack two cycles after mem_req.
        drive(0, 32'h100, 1'b1, 32'hCAFEF00D, 1, 1'b0, lat);
        repeat (2) @(negedge clk);
        drive(0, 32'h100, 1'b0, 32'h0, 2, 1'b0, lat);
        check("latency_read_k2", lat, 4);
        repeat (2) @(negedge clk);

        // Port 1 write, then read back.
        drive(1, 32'h2000, 1'b1, 32'h12345678, 3, 1'b0, lat);
        check("latency_write_k3", lat, 5);
        repeat (2) @(negedge clk);
        drive(1, 32'h2000, 1'b0, 32'h0, 0, 1'b0, lat);
        repeat (2) @(negedge clk);

        // Hung access is aborted, then the next access completes normally.
        drive(0, 32'h180, 1'b0, 32'h0, -1, 1'b0, lat);
        check("latency_timeout", lat, TIMEOUT_CYC + 1);
        repeat (2) @(negedge clk);
        drive(0, 32'h180, 1'b0, 32'h0, 0, 1'b0, lat);
        check("latency_min", lat, 2);
        repeat (2) @(negedge clk);

        // mem_ack on the terminal cycle wins over the abort.
        drive(0, 32'h1C0, 1'b1, 32'hA5A55A5A, TIMEOUT_CYC - 1, 1'b0, lat);
        check("latency_edge", lat, TIMEOUT_CYC + 1);
        repeat (2) @(negedge clk);
        drive(0, 32'h1C0, 1'b0, 32'h0, TIMEOUT_CYC - 1, 1'b0, lat);
        repeat (2) @(negedge clk);

        // Both ports requesting back to back: 0,0,0,0,1 pattern.
        grant_log.delete();
        fork
            for (int i = 0; i < 8; i++)
                drive(0, 32'h300 + i, 1'b0, $urandom, 1, (i < 7), lat0);
            for (int i = 0; i < 2; i++)
                drive(1, 32'h2300 + i, 1'b1, $urandom, 1, (i < 1), lat1);
        join
        check("starve_grant_count", grant_log.size(), 10);
        for (int i = 0; i < 10 && i < grant_log.size(); i++)
            check($sformatf("starve_grant_%0d", i), grant_log[i], exp_pat[i]);
        repeat (2) @(negedge clk);

        // Async reset mid-access with the starvation counter saturated.
        cur_lat[1]  = 1;
        tb_addr[1]  = 32'h2040;
        tb_we[1]    = 1'b0;
        tb_req[1]   = 1'b1;
        for (int i = 0; i < 3; i++)
            drive(0, 32'h200 + i, 1'b0, 32'h0, 1, 1'b1, lat);
        cur_lat[0] = -1;
        tb_addr[0] = 32'h240;
        tb_we[0]   = 1'b0;
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.mem_req) begin
                seen = 1;
                break;
            end
        end
        check("hang_issued", seen, 1);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_mem_req", bus.mem_req, 0);
        check("arst_ack", bus.ack, 0);
        check("arst_err", bus.err, 0);
        check("arst_rdata", bus.rdata, 0);
        check("arst_state", dbg.state, ST_IDLE);
        tb_req[0] = 1'b0;
        tb_req[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        grant_log.delete();
        fork
            drive(0, 32'h280, 1'b0, 32'h0, 2, 1'b0, lat0);
            drive(1, 32'h2080, 1'b0, 32'h0, 2, 1'b0, lat1);
        join
        check("post_reset_first_grant", (grant_log.size() > 0) ? grant_log[0] : 99, 0);
        repeat (2) @(negedge clk);
        drive(1, 32'h2084, 1'b1, 32'h0BADBEEF, 0, 1'b0, lat);
        check("post_reset_p1_alone", lat, 2);

        // Randomized concurrent traffic.
        fork
            for (int i = 0; i < 60; i++) begin
                int k;
                repeat ($urandom_range(2, 4)) @(negedge clk);
                k = ($urandom_range(0, 29) == 0) ? -1 : int'($urandom_range(0, 5));
                drive(0, 32'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), $urandom, k, 1'b0, lat0);
            end
            for (int i = 0; i < 60; i++) begin
                int k;
                repeat ($urandom_range(2, 4)) @(negedge clk);
                k = ($urandom_range(0, 29) == 0) ? -1 : int'($urandom_range(0, 5));
                drive(1, 32'h2000 + 32'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), $urandom, k, 1'b0, lat1);
            end
        join

        repeat (10) @(negedge clk);
        check("exp_q0_drained", exp_q0.size(), 0);
        check("exp_q1_drained", exp_q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
